rr_mux_arb: RTL and testbench

Parametrised N-channel round-robin arbitrating multiplexer with valid/ready handshake and a registered output stage. It generalises the plain 2:1 select to N_CH sources of WIDTH bits. The select is generated internally by a fair rotating-priority arbiter instead of being an external input. It sits wherever several producers share one downstream consumer, such as bus funnels and shared FIFOs.

---
 rtl/rr_mux_arb.sv | 93 +++++++++
 tb/tb_rr_mux_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N-channel round-robin arbitrating mux with registered output stage
module rr_mux_arb #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);

  localparam logic [CW:0]   N_EXT   = (CW+1)'(N_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  logic              load_en;
  logic [CW-1:0]     ptr;
  logic [CW-1:0]     ptr_next;
  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   req_rot;
  logic [CW-1:0]     offset;
  logic              any_req;
  logic [CW:0]       idx_sum;
  logic [CW:0]       idx_wrap;
  logic [CW-1:0]     gnt_idx;
  logic [N_CH-1:0]   grant;
  logic [WIDTH-1:0]  sel_data;

  assign load_en = !out_valid || out_ready;

  // Rotate requests so bit 0 is the channel at ptr; the lowest set bit is then the winner.
  assign req_dbl = {in_valid, in_valid} >> ptr;
  assign req_rot = req_dbl[N_CH-1:0];

  always_comb begin
    any_req = 1'b0;
    offset  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        any_req = 1'b1;
        offset  = CW'(k);
      end
    end
  end

  assign idx_sum  = {1'b0, ptr} + {1'b0, offset};
  assign idx_wrap = idx_sum - N_EXT;
  assign gnt_idx  = (idx_sum >= N_EXT) ? idx_wrap[CW-1:0] : idx_sum[CW-1:0];

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_CH; i++) begin
      grant[i] = any_req && (gnt_idx == CW'(i));
    end
  end

  // Data mux keyed on the one-hot grant keeps in_data out of the in_ready cone.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = load_en ? grant : '0;
  assign ptr_next = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_req) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= gnt_idx;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - self-checking bench for rr_mux_arb
module tb_rr_mux_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_ready;

  rr_mux_arb #(.N_CH(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: next channel to favour plus the output register contents.
  int         m_ptr;
  bit         m_ov;
  logic [7:0] m_od;
  logic [1:0] m_ch;

  typedef struct {
    logic [N-1:0] v;
    bit           ordy;
    logic [N-1:0] rdy;
    bit           ov;
    logic [7:0]   od;
    logic [1:0]   ch;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_ov = 1'b0; m_od = '0; m_ch = '0;
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input bit ordy);
    logic [N-1:0] r;
    int g;
    r = '0;
    if (m_ov && !ordy) return r;
    g = model_pick(v);
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit ordy);
    int g;
    logic [N*W-1:0] t;
    if (m_ov && !ordy) return;
    g = model_pick(v);
    if (g < 0) begin
      m_ov = 1'b0;
    end else begin
      t     = d >> (g * W);
      m_od  = t[W-1:0];
      m_ch  = 2'(g);
      m_ov  = 1'b1;
      m_ptr = (g + 1) % N;
    end
  endtask

  // Applies one cycle of inputs starting just after a rising edge; returns with the next edge done.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input bit ordy,
                       output logic [N-1:0] rdy);
    in_valid = v; in_data = d; out_ready = ordy;
    @(negedge clk);
    rdy = in_ready;
    check("model_in_ready", 32'(in_ready), 32'(model_ready(v, ordy)));
    check("model_out_valid", 32'(out_valid), 32'(m_ov));
    check("model_out_data", 32'(out_data), 32'(m_od));
    check("model_out_ch", 32'(out_ch), 32'(m_ch));
    @(posedge clk);
    model_edge(v, d, ordy);
    #1;
  endtask

  task automatic check_out(input string name, input bit ov, input logic [7:0] od, input logic [1:0] ch);
    check({name, "_valid"}, 32'(out_valid), 32'(ov));
    check({name, "_data"}, 32'(out_data), 32'(od));
    check({name, "_ch"}, 32'(out_ch), 32'(ch));
  endtask

  logic [N-1:0]   rdy;
  logic [N-1:0]   pend;
  logic [W-1:0]   pdat[N];
  int             wait_cnt[N];
  logic [N*W-1:0] d;
  logic [N-1:0]   acc;
  bit             ordy;

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tbl[7]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
    tbl[10] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 8'hA1, 2'd1};
    tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'hA3, 2'd3};
    tbl[12] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'hA0, 2'd0};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'hA0, 2'd0};
    tbl[15] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hA2, 2'd2};

    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention, wrap-around and backpressure as a vector table.
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].v, 32'hA3A2A1A0, tbl[i].ordy, rdy);
      check($sformatf("tbl%0d_in_ready", i), 32'(rdy), 32'(tbl[i].rdy));
      check_out($sformatf("tbl%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ch);
    end

    // Asynchronous reset while the output register holds a word.
    cycle(4'b0001, 32'h00000077, 1'b1, rdy);
    check_out("pre_reset", 1'b1, 8'h77, 2'd0);
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 8'h00, 2'd0);
    check("async_reset_in_ready", 32'(in_ready), 32'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(4'b0001, 32'h00000042, 1'b1, rdy);
    check("post_reset_ready", 32'(rdy), 32'h1);
    check_out("post_reset", 1'b1, 8'h42, 2'd0);

    // Single channel streaming on ch2.
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, {8'h00, 8'(8'h10 + i), 16'h0000}, 1'b1, rdy);
      check_out($sformatf("stream%0d", i), 1'b1, 8'(8'h10 + i), 2'd2);
    end

    // Backpressure holding 0x55 from ch1, then drain and refill on the same edge.
    cycle(4'b0010, 32'h00005500, 1'b1, rdy);
    check_out("bp_load", 1'b1, 8'h55, 2'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1001, 32'h3C0000C0, 1'b0, rdy);
      check($sformatf("bp_stall%0d_ready", i), 32'(rdy), 32'h0);
      check_out($sformatf("bp_stall%0d", i), 1'b1, 8'h55, 2'd1);
    end
    cycle(4'b1001, 32'h3C0000C0, 1'b1, rdy);
    check("bp_release_ready", 32'(rdy), 32'h8);
    check_out("bp_release", 1'b1, 8'h3C, 2'd3);

    // Idle drain: the ch0 word appears for exactly one cycle.
    cycle(4'b0001, 32'h3C0000C0, 1'b1, rdy);
    check_out("drain_word", 1'b1, 8'hC0, 2'd0);
    cycle(4'b0000, 32'h0, 1'b1, rdy);
    check_out("drain_idle0", 1'b0, 8'hC0, 2'd0);
    cycle(4'b0000, 32'h0, 1'b1, rdy);
    check_out("drain_idle1", 1'b0, 8'hC0, 2'd0);

    // Randomized traffic obeying the producer rules, checked against the model plus fairness.
    pend = '0;
    for (int i = 0; i < N; i++) begin
      pdat[i] = '0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = 8'($urandom);
          wait_cnt[i] = 0;
        end
      end
      d = {pdat[3], pdat[2], pdat[1], pdat[0]};
      ordy = ($urandom_range(0, 3) != 0);
      cycle(pend, d, ordy, rdy);
      acc = rdy & pend;
      if (acc != '0) begin
        for (int i = 0; i < N; i++) begin
          if (acc[i]) check($sformatf("fairness_ch%0d", i), 32'(wait_cnt[i] <= N - 1), 32'h1);
          else if (pend[i]) wait_cnt[i]++;
        end
      end
      pend = pend & ~acc;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
